// File: rtl/ctrl_regbank_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_regbank_pkg
//
// Shared constants and types for the cfg_regbank configuration register bank:
//   - APB data width
//   - register offsets inside a channel's 16-word window and inside the
//     global window that follows the last channel
//   - the bank identification constant
//   - the register-kind enumeration produced by the address decoder
//
// Build option: REGBANK_SHADOW_EN selects the shadow/commit variant. When it
// is undefined, configuration writes land directly in the active registers
// and COMMIT becomes read-only.
// ---------------------------------------------------------------------------
package ctrl_regbank_pkg;

    localparam int DATA_W = 16;

    // Offsets within a channel window (off = 16*c + r).
    localparam logic [3:0] STS_OFF = 4'd14;
    localparam logic [3:0] SEL_OFF = 4'd15;

    // Offsets within the global window (off = 16*NUM_CH + r).
    localparam logic [3:0] COMMIT_OFF = 4'd0;
    localparam logic [3:0] PULSE_OFF  = 4'd1;
    localparam logic [3:0] ID_OFF     = 4'd2;

    localparam logic [DATA_W-1:0] REGBANK_ID = 16'hC0B1;

`ifdef REGBANK_SHADOW_EN
    localparam bit SHADOW_EN = 1'b1;
`else
    localparam bit SHADOW_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        K_NONE,
        K_CFG,
        K_STS,
        K_SEL,
        K_COMMIT,
        K_PULSE,
        K_ID
    } reg_kind_e;

    // Register kinds that accept APB writes. COMMIT only exists as a
    // writable register when there are shadow sets to commit.
    function automatic logic kind_writable(input reg_kind_e k);
        logic w;
        w = 1'b0;
        case (k)
            K_CFG, K_SEL, K_PULSE: w = 1'b1;
            K_COMMIT:              w = SHADOW_EN;
            default:               w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cfg_regbank_ch.sv
// ---------------------------------------------------------------------------
// cfg_regbank_ch
//
// One channel of the configuration register bank: REGS_PER_CH config
// registers (shadow + active, or active only), a status capture register,
// a 4-bit readback selector and the channel's update pulse/toggle.
//
// Build option: REGBANK_SHADOW_EN (shadow registers and commit_i exist only
// when defined).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cfg_we_i        write wdata_i to config register idx_i
//   sel_we_i        write wdata_i[3:0] to the selector
//   commit_i        copy the whole shadow set into active (shadow build)
//   idx_i           register index for both writes and readback
//   wdata_i         APB write data
//   sts_we_i/sts_i  status capture strobe and value
//   active_o        flattened active registers, register r at [16r+15:16r]
//   rd_cfg_o        readback of config register idx_i
//   sts_o, sel_o    status and selector readback
//   upd_pulse_o     one-cycle pulse after the active set was updated
//   upd_toggle_o    flips together with every pulse
// ---------------------------------------------------------------------------
module cfg_regbank_ch
    import ctrl_regbank_pkg::*;
#(
    parameter int                REGS_PER_CH = 4,
    parameter logic [DATA_W-1:0] RESET_VAL   = 16'h0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_we_i,
    input  logic                          sel_we_i,
`ifdef REGBANK_SHADOW_EN
    input  logic                          commit_i,
`endif
    input  logic [3:0]                    idx_i,
    input  logic [DATA_W-1:0]             wdata_i,
    input  logic                          sts_we_i,
    input  logic [DATA_W-1:0]             sts_i,
    output logic [REGS_PER_CH*DATA_W-1:0] active_o,
    output logic [DATA_W-1:0]             rd_cfg_o,
    output logic [DATA_W-1:0]             sts_o,
    output logic [3:0]                    sel_o,
    output logic                          upd_pulse_o,
    output logic                          upd_toggle_o
);

    logic [DATA_W-1:0] active_q [REGS_PER_CH];
    logic [DATA_W-1:0] active_d [REGS_PER_CH];
`ifdef REGBANK_SHADOW_EN
    logic [DATA_W-1:0] shadow_q [REGS_PER_CH];
    logic [DATA_W-1:0] shadow_d [REGS_PER_CH];
`endif
    logic [DATA_W-1:0] sts_q, sts_d;
    logic [3:0]        sel_q, sel_d;
    logic              upd_pulse_q, upd_pulse_d;
    logic              upd_toggle_q, upd_toggle_d;

    always_comb begin
        active_d    = active_q;
        sts_d       = sts_we_i ? sts_i : sts_q;
        sel_d       = sel_we_i ? wdata_i[3:0] : sel_q;
        upd_pulse_d = 1'b0;
`ifdef REGBANK_SHADOW_EN
        shadow_d = shadow_q;
        for (int r = 0; r < REGS_PER_CH; r++) begin
            if (cfg_we_i && (idx_i == 4'(r))) begin
                shadow_d[r] = wdata_i;
            end
        end
        // The whole set moves in one edge; an unchanged set still pulses so
        // downstream sees every commit.
        if (commit_i) begin
            active_d    = shadow_q;
            upd_pulse_d = 1'b1;
        end
`else
        for (int r = 0; r < REGS_PER_CH; r++) begin
            if (cfg_we_i && (idx_i == 4'(r))) begin
                active_d[r] = wdata_i;
                upd_pulse_d = 1'b1;
            end
        end
`endif
        upd_toggle_d = upd_toggle_q ^ upd_pulse_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REGS_PER_CH; r++) begin
                active_q[r] <= RESET_VAL;
`ifdef REGBANK_SHADOW_EN
                shadow_q[r] <= RESET_VAL;
`endif
            end
            sts_q        <= '0;
            sel_q        <= '0;
            upd_pulse_q  <= 1'b0;
            upd_toggle_q <= 1'b0;
        end else begin
            active_q     <= active_d;
`ifdef REGBANK_SHADOW_EN
            shadow_q     <= shadow_d;
`endif
            sts_q        <= sts_d;
            sel_q        <= sel_d;
            upd_pulse_q  <= upd_pulse_d;
            upd_toggle_q <= upd_toggle_d;
        end
    end

    // Config readback: shadow by default, active when selector bit 0 is set.
    // Without shadow registers only the active set exists.
    always_comb begin
        rd_cfg_o = '0;
        for (int r = 0; r < REGS_PER_CH; r++) begin
            if (idx_i == 4'(r)) begin
`ifdef REGBANK_SHADOW_EN
                rd_cfg_o = sel_q[0] ? active_q[r] : shadow_q[r];
`else
                rd_cfg_o = active_q[r];
`endif
            end
        end
    end

    for (genvar r = 0; r < REGS_PER_CH; r++) begin : g_active
        assign active_o[r*DATA_W +: DATA_W] = active_q[r];
    end

    assign sts_o        = sts_q;
    assign sel_o        = sel_q;
    assign upd_pulse_o  = upd_pulse_q;
    assign upd_toggle_o = upd_toggle_q;

endmodule

// File: rtl/cfg_regbank.sv
// ---------------------------------------------------------------------------
// cfg_regbank
//
// APB slave configuration register bank for NUM_CH channels. Holds the APB
// decode, the read wait counter, the registered read mux and the software
// PULSE register; per-channel storage lives in cfg_regbank_ch.
//
// Build option: REGBANK_SHADOW_EN (shadow/commit variant when defined,
// direct-write variant when undefined).
//
// Ports:
//   clk_200m, rstn_200m       control clock, asynchronous active-low reset
//   req_psel/penable/pwrite   APB controls
//   req_paddr, req_pwdata     APB word address and write data
//   req_pready, req_prdata    transfer complete, read data
//   req_pslverr               error, valid with req_pready
//   sts_i, sts_we_i           per-channel status values and capture strobes
//   cfg_o                     active config, channel c reg r at word c*REGS_PER_CH+r
//   cfg_upd_pulse_o           one-cycle pulse per channel on active-set update
//   cfg_upd_toggle_o          per-channel toggle, flips with each pulse
//   sw_pulse_o                software self-clearing pulses
// ---------------------------------------------------------------------------
module cfg_regbank
    import ctrl_regbank_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                REGS_PER_CH = 4,
    parameter int                ADDR_W      = 21,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                RD_WAIT     = 0,
    parameter logic [DATA_W-1:0] RESET_VAL   = 16'h0000
) (
    input  logic                                 clk_200m,
    input  logic                                 rstn_200m,
    input  logic                                 req_psel,
    input  logic                                 req_penable,
    input  logic                                 req_pwrite,
    input  logic [ADDR_W-1:0]                    req_paddr,
    input  logic [DATA_W-1:0]                    req_pwdata,
    output logic                                 req_pready,
    output logic [DATA_W-1:0]                    req_prdata,
    output logic                                 req_pslverr,
    input  logic [NUM_CH*DATA_W-1:0]             sts_i,
    input  logic [NUM_CH-1:0]                    sts_we_i,
    output logic [NUM_CH*REGS_PER_CH*DATA_W-1:0] cfg_o,
    output logic [NUM_CH-1:0]                    cfg_upd_pulse_o,
    output logic [NUM_CH-1:0]                    cfg_upd_toggle_o,
    output logic [DATA_W-1:0]                    sw_pulse_o
);

    localparam logic [ADDR_W-5:0] NUM_CH_A  = (ADDR_W-4)'(NUM_CH);
    localparam logic [3:0]        REGS_A    = 4'(REGS_PER_CH);
    localparam logic [1:0]        RD_WAIT_C = 2'(RD_WAIT);

    // ---------------- address decode ----------------
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-5:0] ch_idx;
    logic [3:0]        reg_idx;
    reg_kind_e         kind;
    logic              acc_err;

    always_comb begin
        off     = req_paddr - BASE_ADDR;
        ch_idx  = off[ADDR_W-1:4];
        reg_idx = off[3:0];
        kind    = K_NONE;
        if (req_paddr >= BASE_ADDR) begin
            if (ch_idx < NUM_CH_A) begin
                if (reg_idx < REGS_A)          kind = K_CFG;
                else if (reg_idx == STS_OFF)   kind = K_STS;
                else if (reg_idx == SEL_OFF)   kind = K_SEL;
            end else if (ch_idx == NUM_CH_A) begin
                if (reg_idx == COMMIT_OFF)     kind = K_COMMIT;
                else if (reg_idx == PULSE_OFF) kind = K_PULSE;
                else if (reg_idx == ID_OFF)    kind = K_ID;
            end
        end
        acc_err = (kind == K_NONE) || (req_pwrite && !kind_writable(kind));
    end

    // ---------------- per-channel readback ----------------
    logic [DATA_W-1:0] ch_rd_cfg [NUM_CH];
    logic [DATA_W-1:0] ch_sts    [NUM_CH];
    logic [3:0]        ch_sel    [NUM_CH];
    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == (ADDR_W-4)'(c)) begin
                case (kind)
                    K_CFG:   rd_mux = ch_rd_cfg[c];
                    K_STS:   rd_mux = ch_sts[c];
                    K_SEL:   rd_mux = {12'h000, ch_sel[c]};
                    default: ;
                endcase
            end
        end
        if (kind == K_ID) rd_mux = REGBANK_ID;
    end

    // ---------------- APB sequencing ----------------
    // Handshake: a transfer is one setup cycle (psel & !penable) followed by
    // access cycles (psel & penable) until pready is seen high; the transfer
    // completes on the edge that ends the pready cycle. pslverr and prdata
    // are only meaningful while pready is high. Dropping psel before pready
    // abandons the transfer with no side effects.
    logic              pready_q, pready_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] pulse_q, pulse_d;
    logic              setup, access, wr_fire;

    assign setup   = req_psel && !req_penable;
    assign access  = req_psel && req_penable;
    // Writes use the error flag captured at setup; the address is stable
    // through the transfer so it matches the current decode.
    assign wr_fire = access && req_pwrite && pready_q && !err_q;

    always_comb begin
        pready_d   = 1'b0;
        err_d      = err_q;
        prdata_d   = prdata_q;
        wait_cnt_d = wait_cnt_q;
        if (!req_psel) begin
            wait_cnt_d = '0;
        end else if (setup) begin
            wait_cnt_d = '0;
            pready_d   = req_pwrite || (RD_WAIT == 0);
            err_d      = acc_err;
            // Read data is frozen here, so a status capture on this same
            // edge is not visible to this read.
            prdata_d   = (req_pwrite || acc_err) ? '0 : rd_mux;
        end else if (!pready_q) begin
            wait_cnt_d = wait_cnt_q + 2'd1;
            pready_d   = ((wait_cnt_q + 2'd1) == RD_WAIT_C);
        end
        pulse_d = (wr_fire && (kind == K_PULSE)) ? req_pwdata : '0;
    end

    always_ff @(posedge clk_200m or negedge rstn_200m) begin
        if (!rstn_200m) begin
            pready_q   <= 1'b0;
            err_q      <= 1'b0;
            prdata_q   <= '0;
            wait_cnt_q <= '0;
            pulse_q    <= '0;
        end else begin
            pready_q   <= pready_d;
            err_q      <= err_d;
            prdata_q   <= prdata_d;
            wait_cnt_q <= wait_cnt_d;
            pulse_q    <= pulse_d;
        end
    end

    assign req_pready  = pready_q;
    assign req_pslverr = pready_q && err_q;
    assign req_prdata  = prdata_q;
    assign sw_pulse_o  = pulse_q;

    // ---------------- channels ----------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic ch_hit;
        assign ch_hit = (ch_idx == (ADDR_W-4)'(c));

        cfg_regbank_ch #(
            .REGS_PER_CH (REGS_PER_CH),
            .RESET_VAL   (RESET_VAL)
        ) u_ch (
            .clk          (clk_200m),
            .rst_n        (rstn_200m),
            .cfg_we_i     (wr_fire && (kind == K_CFG) && ch_hit),
            .sel_we_i     (wr_fire && (kind == K_SEL) && ch_hit),
`ifdef REGBANK_SHADOW_EN
            // Bits at or above NUM_CH have no channel and are dropped here.
            .commit_i     (wr_fire && (kind == K_COMMIT) && req_pwdata[c]),
`endif
            .idx_i        (reg_idx),
            .wdata_i      (req_pwdata),
            .sts_we_i     (sts_we_i[c]),
            .sts_i        (sts_i[c*DATA_W +: DATA_W]),
            .active_o     (cfg_o[c*REGS_PER_CH*DATA_W +: REGS_PER_CH*DATA_W]),
            .rd_cfg_o     (ch_rd_cfg[c]),
            .sts_o        (ch_sts[c]),
            .sel_o        (ch_sel[c]),
            .upd_pulse_o  (cfg_upd_pulse_o[c]),
            .upd_toggle_o (cfg_upd_toggle_o[c])
        );
    end

endmodule

// File: tb/tb_cfg_regbank.sv
// ---------------------------------------------------------------------------
// tb_cfg_regbank
//
// Self-checking bench for cfg_regbank (NUM_CH=4, REGS_PER_CH=4, RD_WAIT=2,
// non-zero base address). Works for both builds: REGBANK_SHADOW_EN selects
// the reference model's shadow behaviour. APB responses are predicted into
// an expected queue and compared by an independent monitor; side outputs
// (cfg_o, pulses, toggles) are compared right after each write completes.
// ---------------------------------------------------------------------------
module tb_cfg_regbank;

    localparam int                NUM_CH  = 4;
    localparam int                REGS    = 4;
    localparam int                ADDR_W  = 21;
    localparam int                RD_WAIT = 2;
    localparam logic [ADDR_W-1:0] BASE    = 21'h000200;
    localparam int                W       = 21;  // {latency[3:0], err, data[15:0]}

`ifdef REGBANK_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    // model register kinds
    localparam int M_NONE = 0, M_CFG = 1, M_STS = 2, M_SEL = 3,
                   M_COMMIT = 4, M_PULSE = 5, M_ID = 6;

    logic                         clk;
    logic                         rstn;
    logic                         psel, penable, pwrite;
    logic [ADDR_W-1:0]            paddr;
    logic [15:0]                  pwdata;
    logic                         pready;
    logic [15:0]                  prdata;
    logic                         pslverr;
    logic [NUM_CH*16-1:0]         sts_i;
    logic [NUM_CH-1:0]            sts_we;
    logic [NUM_CH*REGS*16-1:0]    cfg_o;
    logic [NUM_CH-1:0]            upd_pulse;
    logic [NUM_CH-1:0]            upd_toggle;
    logic [15:0]                  sw_pulse;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    // reference model state
    logic [15:0]       m_shadow [NUM_CH][REGS];
    logic [15:0]       m_active [NUM_CH][REGS];
    logic [15:0]       m_sts    [NUM_CH];
    logic [3:0]        m_sel    [NUM_CH];
    logic [NUM_CH-1:0] m_toggle;

    cfg_regbank #(
        .NUM_CH      (NUM_CH),
        .REGS_PER_CH (REGS),
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE),
        .RD_WAIT     (RD_WAIT),
        .RESET_VAL   (16'h0000)
    ) dut (
        .clk_200m         (clk),
        .rstn_200m        (rstn),
        .req_psel         (psel),
        .req_penable      (penable),
        .req_pwrite       (pwrite),
        .req_paddr        (paddr),
        .req_pwdata       (pwdata),
        .req_pready       (pready),
        .req_prdata       (prdata),
        .req_pslverr      (pslverr),
        .sts_i            (sts_i),
        .sts_we_i         (sts_we),
        .cfg_o            (cfg_o),
        .cfg_upd_pulse_o  (upd_pulse),
        .cfg_upd_toggle_o (upd_toggle),
        .sw_pulse_o       (sw_pulse)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] addr_of(input int c, input int r);
        return BASE + ADDR_W'(16 * c + r);
    endfunction

    function automatic int m_kind(input logic [ADDR_W-1:0] a, output int c, output int r);
        int o;
        c = 0;
        r = 0;
        if (a < BASE) return M_NONE;
        o = int'(a - BASE);
        c = o / 16;
        r = o % 16;
        if (c < NUM_CH) begin
            if (r < REGS) return M_CFG;
            if (r == 14)  return M_STS;
            if (r == 15)  return M_SEL;
            return M_NONE;
        end
        if (c == NUM_CH) begin
            if (r == 0) return M_COMMIT;
            if (r == 1) return M_PULSE;
            if (r == 2) return M_ID;
        end
        return M_NONE;
    endfunction

    function automatic logic [NUM_CH*REGS*16-1:0] m_cfg_flat();
        logic [NUM_CH*REGS*16-1:0] v;
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < REGS; r++)
                v[(c*REGS + r)*16 +: 16] = m_active[c][r];
        return v;
    endfunction

    // {err, data} a read of address a should return
    function automatic logic [16:0] m_read(input logic [ADDR_W-1:0] a);
        int c, r, k;
        k = m_kind(a, c, r);
        case (k)
            M_CFG: begin
                if (SHADOW && !m_sel[c][0]) return {1'b0, m_shadow[c][r]};
                return {1'b0, m_active[c][r]};
            end
            M_STS:    return {1'b0, m_sts[c]};
            M_SEL:    return {1'b0, 12'h000, m_sel[c]};
            M_COMMIT: return 17'h0;
            M_PULSE:  return 17'h0;
            M_ID:     return {1'b0, 16'hC0B1};
            default:  return {1'b1, 16'h0000};
        endcase
    endfunction

    task automatic m_write(input logic [ADDR_W-1:0] a, input logic [15:0] d,
                           output logic err, output logic [NUM_CH-1:0] upd,
                           output logic [15:0] sw);
        int c, r, k;
        k   = m_kind(a, c, r);
        err = 1'b0;
        upd = '0;
        sw  = '0;
        case (k)
            M_CFG: begin
                if (SHADOW) m_shadow[c][r] = d;
                else begin
                    m_active[c][r] = d;
                    upd[c] = 1'b1;
                end
            end
            M_SEL: m_sel[c] = d[3:0];
            M_COMMIT: begin
                if (SHADOW) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (d[i]) begin
                            for (int j = 0; j < REGS; j++) m_active[i][j] = m_shadow[i][j];
                            upd[i] = 1'b1;
                        end
                    end
                end else err = 1'b1;
            end
            M_PULSE: sw = d;
            default: err = 1'b1;
        endcase
        m_toggle = m_toggle ^ upd;
    endtask

    task automatic m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = 0; r < REGS; r++) begin
                m_shadow[c][r] = 16'h0000;
                m_active[c][r] = 16'h0000;
            end
            m_sts[c] = 16'h0000;
            m_sel[c] = 4'h0;
        end
        m_toggle = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: pready not seen within 10 cycles", name);
            void'(exp_q.pop_back());
        end
    endtask

    task automatic apb_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        logic err;
        logic [NUM_CH-1:0] upd;
        logic [15:0] sw;
        m_write(a, d, err, upd, sw);
        exp_q.push_back({4'd1, err, 16'h0000});
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        wait_ready("write");
        check("cfg_o", cfg_o, m_cfg_flat());
        check("upd_pulse", upd_pulse, upd);
        check("upd_toggle", upd_toggle, m_toggle);
        check("sw_pulse", sw_pulse, sw);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        check("upd_pulse_clear", upd_pulse, 0);
        check("sw_pulse_clear", sw_pulse, 0);
    endtask

    task automatic apb_read(input logic [ADDR_W-1:0] a, input bit sts_pulse,
                            input int sc, input logic [15:0] sv);
        exp_q.push_back({4'(RD_WAIT + 1), m_read(a)});
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        if (sts_pulse) begin
            sts_i[sc*16 +: 16] = sv;
            sts_we[sc] = 1'b1;
        end
        @(posedge clk); #1;
        penable = 1'b1;
        sts_we = '0;
        if (sts_pulse) m_sts[sc] = sv;
        wait_ready("read");
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic set_sts(input int c, input logic [15:0] v);
        sts_i[c*16 +: 16] = v;
        sts_we[c] = 1'b1;
        @(posedge clk); #1;
        sts_we = '0;
        m_sts[c] = v;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        int acc;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        acc = 0;
        forever begin
            @(negedge clk);
            if (!rstn || !psel || !penable) begin
                acc = 0;
            end else begin
                acc++;
                if (pready) begin
                    got = {4'(acc), pslverr, prdata};
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL apb_unexpected: response %0h with nothing expected", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL apb_resp addr=%0h: got lat/err/data %0h expected %0h",
                                     paddr, got, exp);
                        end
                    end
                    acc = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [ADDR_W-1:0] a;
        int op;
        rstn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; sts_i = '0; sts_we = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", pready, 0);
        check("rst_prdata", prdata, 0);
        check("rst_pslverr", pslverr, 0);
        check("rst_cfg_o", cfg_o, 0);
        check("rst_upd_pulse", upd_pulse, 0);
        check("rst_upd_toggle", upd_toggle, 0);
        check("rst_sw_pulse", sw_pulse, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // basic reads
        apb_read(addr_of(0, 0), 1'b0, 0, 16'h0);
        apb_read(addr_of(NUM_CH, 2), 1'b0, 0, 16'h0);

        // shadow write, readback, commit
        apb_write(addr_of(1, 2), 16'h1234);
        apb_read(addr_of(1, 2), 1'b0, 0, 16'h0);
        apb_write(addr_of(NUM_CH, 0), 16'h0002);
        apb_read(addr_of(1, 2), 1'b0, 0, 16'h0);

        // selector: read active vs shadow
        apb_write(addr_of(1, 2), 16'h5555);
        apb_write(addr_of(1, 15), 16'h0001);
        apb_read(addr_of(1, 2), 1'b0, 0, 16'h0);
        apb_read(addr_of(1, 15), 1'b0, 0, 16'h0);

        // errors: unmapped, RO writes, below base
        apb_write(addr_of(NUM_CH, 5), 16'hFFFF);
        apb_write(addr_of(2, 14), 16'hAAAA);
        apb_write(addr_of(NUM_CH, 2), 16'h0001);
        apb_read(BASE - 21'd1, 1'b0, 0, 16'h0);
        apb_read(addr_of(0, 5), 1'b0, 0, 16'h0);

        // status capture and same-cycle capture during read setup
        set_sts(3, 16'hBEEF);
        apb_read(addr_of(3, 14), 1'b0, 0, 16'h0);
        apb_read(addr_of(3, 14), 1'b1, 3, 16'h1111);
        apb_read(addr_of(3, 14), 1'b0, 0, 16'h0);

        // software pulse, commit bits above NUM_CH, re-commit of equal set
        apb_write(addr_of(NUM_CH, 1), 16'h8001);
        apb_write(addr_of(NUM_CH, 0), 16'hFFF0);
        apb_write(addr_of(NUM_CH, 0), 16'h0002);

        // aborted read: psel drops after one access cycle
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr_of(0, 0);
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_pready", pready, 0);
        end
        @(posedge clk); #1;
        apb_read(addr_of(1, 2), 1'b0, 0, 16'h0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 5);
            a  = BASE - 21'd2 + ADDR_W'($urandom_range(0, 16 * NUM_CH + 9));
            case (op)
                0, 1: apb_write(a, 16'($urandom));
                2:    apb_read(a, 1'b0, 0, 16'h0);
                3:    apb_write(addr_of(NUM_CH, 0), 16'($urandom_range(0, 31)));
                4:    set_sts($urandom_range(0, NUM_CH - 1), 16'($urandom));
                default: apb_read(addr_of($urandom_range(0, NUM_CH - 1), 14), 1'b1,
                                  $urandom_range(0, NUM_CH - 1), 16'($urandom));
            endcase
        end

        // reset asserted in the middle of a read
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr_of(NUM_CH, 2);
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_pready", pready, 0);
        check("midrst_prdata", prdata, 0);
        check("midrst_cfg_o", cfg_o, 0);
        check("midrst_upd_toggle", upd_toggle, 0);
        check("midrst_sw_pulse", sw_pulse, 0);
        psel = 1'b0; penable = 1'b0;
        m_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        apb_read(addr_of(1, 2), 1'b0, 0, 16'h0);
        apb_read(addr_of(3, 14), 1'b0, 0, 16'h0);

        repeat (4) @(posedge clk);
        check("exp_queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
